rf_arbiter: RTL and testbench
=============================

RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 reqN  in  1  (N=0,1) requester N has an operation pending; held until ackN.
REQ-005 opN  in  2  operation: 00 READ, 01 WRITE, 10 INC pair, 11 DEC pair.
REQ-006 addrN  in  4  target register index; the pair is {addr+1 mod 16, addr}.
REQ-007 wdataN  in  8  write data (WRITE only).
REQ-008 lock1  in  1  requester 1 holds the grant while asserted with req1.
REQ-009 ackN  out  1  one-cycle pulse: operation issued to the register file this cycle.
REQ-010 rdataN  out  16  {reg[addr+1], reg[addr]} of the last READ by N.
REQ-011 rf_in_select, rf_outb_select  out  4 each  register file select lines.
REQ-012 rf_in  out  8;  rf_write_en, rf_inc, rf_dec  out  1 each  register file command.
REQ-013 rf_outb, rf_outc  in  8 each  register file read data (combinational).

Function
REQ-014 All rf_* command outputs and ackN shall be registered; a request sampled in cycle N shall be issued and acked in cycle N+1.
REQ-015 At most one operation shall be issued per cycle; at most one of rf_write_en, rf_inc, rf_dec shall be high.
REQ-016 WRITE: rf_in_select=addr, rf_in=wdata, rf_write_en=1.
REQ-016a INC/DEC: rf_outb_select=addr, rf_inc or rf_dec=1.
REQ-016b READ: rf_outb_select=addr, no strobe.
REQ-017 While idle, all strobes shall be 0 and the select outputs shall hold their last values.
REQ-018 A requester acked in cycle N shall not be eligible for selection in cycle N; its next operation may be issued in N+2 at the earliest.
REQ-019 Arbitration shall be round-robin: on contention, the requester not granted most recently wins. Single requests shall win immediately.
REQ-020 Lock: if requester 1 was granted and lock1&req1 is high at its next eligibility, requester 1 shall win regardless of round-robin.
REQ-020a Requester 0 shall wait while the lock holds; an issue slot lost to REQ-018 shall not be given to requester 0.
REQ-021 On a READ ack, {rf_outc, rf_outb} shall be registered into rdataN at the end of the ack cycle. rdataN shall be valid from the following cycle and held until N's next READ ack.
REQ-022 Pair address wrap: addr=15 pairs with register 0; no rejection or error.
REQ-023 Dropping reqN before ackN shall cancel the request if not yet selected; a selected operation shall complete regardless.

Reset
REQ-024 On rst: ack0=ack1=0, strobes=0, selects=0, rf_in=0, rdata0=rdata1=0, round-robin pointer to requester 0, lock state cleared.
REQ-025 rst asserted mid-operation shall suppress the pending issue: no strobe in the cycle after rst.

Configuration
REQ-026 Macro RF_ARB_FIXED_PRIORITY_EN: when defined, requester 1 shall always win contention and the round-robin pointer is removed. Lock behaviour is unchanged. When undefined, round-robin per REQ-019.

Structure
REQ-027 Package rf_arb_pkg shall hold the op encodings (READ/WRITE/INC/DEC) and the register index width constant.
REQ-028 Sub-module rr_arb2 shall contain the 2-way winner selection, including the pointer, eligibility masking and lock. rf_arbiter shall contain command registering and rdata capture.

Verification
REQ-029 req0 WRITE addr=3 wdata=0xA5, alone -> next cycle ack0=1, rf_write_en=1, rf_in_select=3, rf_in=0xA5; then idle.
REQ-030 req0 and req1 both INC continuously from reset -> issue order 0,1,0,1...; one strobe per cycle, never two.
REQ-031 Pair {r5,r4}=0x00FF, req1 INC addr=4 then READ addr=4 -> rdata1=0x0100.
REQ-032 req1 with lock1=1 for 3 ops while req0 pending -> requester 0 gets no ack until lock1 drops; first issue after drop is requester 0.
REQ-033 Pair {r0,r15}=0x00FF, DEC addr=15 -> READ addr=15 returns 0x00FE; INC addr=15 from {r0,r15}=0x00FF returns 0x0100, with r0=0x01.
REQ-034 Assert rst in the cycle a request is sampled -> no ack and no strobe the next cycle; all outputs at reset values.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared encodings and widths for the register-file arbiter.
package rf_arb_pkg;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_DEC   = 2'b11
  } rf_op_e;

  typedef struct packed {
    rf_op_e                 op;
    logic [REG_IDX_W-1:0]   addr;
    logic [DATA_W-1:0]      wdata;
  } rf_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way winner selection with issue-slot masking, round-robin pointer and requester-1 lock.
// Build option: RF_ARB_FIXED_PRIORITY_EN makes requester 1 win all contention (no pointer).
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] busy_i,
  input  logic       lock1_i,
  output logic [1:0] gnt_c
);

  logic [1:0] elig;
  logic       lock_q, lock_d;
  logic       lock_hold;

  // A requester acked this cycle is still presenting its old request.
  assign elig      = req_i & ~busy_i;
  assign lock_hold = lock_q & lock1_i & req_i[1];

`ifdef RF_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt_c = elig;
    if (lock_hold) begin
      gnt_c = {elig[1], 1'b0};
    end else if (elig == 2'b11) begin
      gnt_c = 2'b10;
    end
  end
`else
  logic prio_q, prio_d;

  always_comb begin
    gnt_c = elig;
    if (lock_hold) begin
      gnt_c = {elig[1], 1'b0};
    end else if (elig == 2'b11) begin
      gnt_c = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_c[0]) prio_d = 1'b1;
    if (gnt_c[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`endif

  // Lock only applies when requester 1 owned the most recent grant.
  always_comb begin
    lock_d = lock_q;
    if (gnt_c[0]) lock_d = 1'b0;
    if (gnt_c[1]) lock_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end

endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two requesters onto one register-file command port; registers commands and read data.
// Build option: RF_ARB_FIXED_PRIORITY_EN (see rr_arb2).
module rf_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [1:0]             op0,
  input  logic [REG_IDX_W-1:0]   addr0,
  input  logic [DATA_W-1:0]      wdata0,
  input  logic                   req1,
  input  logic [1:0]             op1,
  input  logic [REG_IDX_W-1:0]   addr1,
  input  logic [DATA_W-1:0]      wdata1,
  input  logic                   lock1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [2*DATA_W-1:0]    rdata0,
  output logic [2*DATA_W-1:0]    rdata1,
  output logic [REG_IDX_W-1:0]   rf_in_select,
  output logic [REG_IDX_W-1:0]   rf_outb_select,
  output logic [DATA_W-1:0]      rf_in,
  output logic                   rf_write_en,
  output logic                   rf_inc,
  output logic                   rf_dec,
  input  logic [DATA_W-1:0]      rf_outb,
  input  logic [DATA_W-1:0]      rf_outc
);

  logic [NREQ-1:0]        req_v, gnt, ack_q, ack_d, rd_q, rd_d;
  rf_req_t                sel;
  logic                   we_q, we_d, inc_q, inc_d, dec_q, dec_d;
  logic [REG_IDX_W-1:0]   isel_q, isel_d, osel_q, osel_d;
  logic [DATA_W-1:0]      rfin_q, rfin_d;
  logic [2*DATA_W-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  assign req_v = {req1, req0};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_v),
    .busy_i  (ack_q),
    .lock1_i (lock1),
    .gnt_c   (gnt)
  );

  assign sel = gnt[1] ? {op1, addr1, wdata1} : {op0, addr0, wdata0};

  // Next command: strobes default low, selects and write data hold.
  always_comb begin
    ack_d  = '0;
    rd_d   = '0;
    we_d   = 1'b0;
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    isel_d = isel_q;
    osel_d = osel_q;
    rfin_d = rfin_q;
    if (|gnt) begin
      ack_d = gnt;
      unique case (sel.op)
        OP_WRITE: begin
          isel_d = sel.addr;
          rfin_d = sel.wdata;
          we_d   = 1'b1;
        end
        OP_INC: begin
          osel_d = sel.addr;
          inc_d  = 1'b1;
        end
        OP_DEC: begin
          osel_d = sel.addr;
          dec_d  = 1'b1;
        end
        OP_READ: begin
          osel_d = sel.addr;
          rd_d   = gnt;
        end
      endcase
    end
  end

  // Read data is sampled at the end of the READ ack cycle.
  always_comb begin
    rdata0_d = rd_q[0] ? {rf_outc, rf_outb} : rdata0_q;
    rdata1_d = rd_q[1] ? {rf_outc, rf_outb} : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      isel_q   <= '0;
      osel_q   <= '0;
      rfin_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack_q    <= ack_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      isel_q   <= isel_d;
      osel_q   <= osel_d;
      rfin_q   <= rfin_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0           = ack_q[0];
  assign ack1           = ack_q[1];
  assign rf_write_en    = we_q;
  assign rf_inc         = inc_q;
  assign rf_dec         = dec_q;
  assign rf_in_select   = isel_q;
  assign rf_outb_select = osel_q;
  assign rf_in          = rfin_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter: per-cycle vector table plus read-back sequences against a register-file model.
module tb_rf_arbiter;

  localparam logic [1:0] R = 2'b00, W = 2'b01, I = 2'b10, D = 2'b11;

  logic        clk, rst;
  logic        req0, req1, lock1;
  logic [1:0]  op0, op1;
  logic [3:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [3:0]  rf_in_select, rf_outb_select;
  logic [7:0]  rf_in, rf_outb, rf_outc;
  logic        rf_write_en, rf_inc, rf_dec;

  int compared = 0;
  int mismatched = 0;

  rf_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1),
    .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .rf_in_select(rf_in_select), .rf_outb_select(rf_outb_select),
    .rf_in(rf_in), .rf_write_en(rf_write_en), .rf_inc(rf_inc), .rf_dec(rf_dec),
    .rf_outb(rf_outb), .rf_outc(rf_outc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: 16 x 8 bits, pair = {reg[sel+1], reg[sel]}.
  logic [7:0]  regs [16];
  logic [3:0]  hi_idx;
  logic [15:0] pair;
  assign hi_idx  = rf_outb_select + 4'd1;
  assign rf_outb = regs[rf_outb_select];
  assign rf_outc = regs[hi_idx];
  assign pair    = {regs[hi_idx], regs[rf_outb_select]};

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) regs[k] <= 8'h00;
    end else begin
      if (rf_write_en) regs[rf_in_select] <= rf_in;
      if (rf_inc) {regs[hi_idx], regs[rf_outb_select]} <= pair + 16'd1;
      if (rf_dec) {regs[hi_idx], regs[rf_outb_select]} <= pair - 16'd1;
    end
  end

  typedef struct packed {
    logic        rst;
    logic        r0;
    logic [1:0]  op0;
    logic [3:0]  a0;
    logic [7:0]  d0;
    logic        r1;
    logic [1:0]  op1;
    logic [3:0]  a1;
    logic [7:0]  d1;
    logic        lk;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected output word: {ack0, ack1, we, inc, dec, in_sel, outb_sel, rf_in}.
  function automatic logic [20:0] e(input logic a0, input logic a1, input logic we,
                                    input logic inc, input logic dec, input logic [3:0] isel,
                                    input logic [3:0] osel, input logic [7:0] din);
    return {a0, a1, we, inc, dec, isel, osel, din};
  endfunction

  function automatic vec_t v(input logic rs, input logic r0, input logic [1:0] o0,
                             input logic [3:0] a0, input logic [7:0] d0, input logic r1,
                             input logic [1:0] o1, input logic [3:0] a1, input logic [7:0] d1,
                             input logic lk, input logic [20:0] ex);
    vec_t t;
    t = '{rst: rs, r0: r0, op0: o0, a0: a0, d0: d0, r1: r1, op1: o1, a1: a1, d1: d1, lk: lk, exp: ex};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one op on requester `who` and hold it until acked (bounded).
  task automatic do_op(input int who, input logic [1:0] op, input logic [3:0] addr,
                       input logic [7:0] wd);
    bit seen = 0;
    if (who == 0) begin req0 = 1'b1; op0 = op; addr0 = addr; wdata0 = wd; end
    else          begin req1 = 1'b1; op1 = op; addr1 = addr; wdata1 = wd; end
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if ((who == 0 && ack0) || (who == 1 && ack1)) seen = 1;
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    check($sformatf("ack_seen_req%0d", who), 32'(seen), 32'd1);
  endtask

  initial begin
    logic [20:0] got;
    rst = 1'b1; req0 = 0; req1 = 0; lock1 = 0;
    op0 = R; op1 = R; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    tbl.push_back(v(1, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h0,4'h0,8'h00)));
    tbl.push_back(v(0, 1,W,3,8'hA5, 0,R,0,8'h00, 0, e(1,0,1,0,0,4'h3,4'h0,8'hA5)));
    tbl.push_back(v(0, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h3,4'h0,8'hA5)));
    tbl.push_back(v(0, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h3,4'h0,8'hA5)));
    tbl.push_back(v(1, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h0,4'h0,8'h00)));
    tbl.push_back(v(0, 1,I,2,8'h00, 1,I,7,8'h00, 0, e(1,0,0,1,0,4'h0,4'h2,8'h00)));
    tbl.push_back(v(0, 1,I,2,8'h00, 1,I,7,8'h00, 0, e(0,1,0,1,0,4'h0,4'h7,8'h00)));
    tbl.push_back(v(0, 1,I,2,8'h00, 1,I,7,8'h00, 0, e(1,0,0,1,0,4'h0,4'h2,8'h00)));
    tbl.push_back(v(0, 1,I,2,8'h00, 1,I,7,8'h00, 0, e(0,1,0,1,0,4'h0,4'h7,8'h00)));
    tbl.push_back(v(0, 1,I,2,8'h00, 1,I,7,8'h00, 0, e(1,0,0,1,0,4'h0,4'h2,8'h00)));
    tbl.push_back(v(0, 0,R,0,8'h00, 1,I,7,8'h00, 0, e(0,1,0,1,0,4'h0,4'h7,8'h00)));
    tbl.push_back(v(0, 0,R,0,8'h00, 1,I,7,8'h00, 0, e(0,0,0,0,0,4'h0,4'h7,8'h00)));
    tbl.push_back(v(0, 0,R,0,8'h00, 1,D,9,8'h00, 0, e(0,1,0,0,1,4'h0,4'h9,8'h00)));
    tbl.push_back(v(0, 1,R,5,8'h00, 0,R,0,8'h00, 0, e(1,0,0,0,0,4'h0,4'h5,8'h00)));
    tbl.push_back(v(0, 1,W,1,8'h11, 1,W,14,8'h22, 0, e(0,1,1,0,0,4'hE,4'h5,8'h22)));
    tbl.push_back(v(0, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'hE,4'h5,8'h22)));
    tbl.push_back(v(0, 1,W,1,8'h11, 1,W,14,8'h22, 0, e(1,0,1,0,0,4'h1,4'h5,8'h11)));
    tbl.push_back(v(0, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h1,4'h5,8'h11)));
    tbl.push_back(v(0, 1,W,1,8'h11, 1,W,14,8'h22, 0, e(0,1,1,0,0,4'hE,4'h5,8'h22)));
    tbl.push_back(v(1, 1,W,3,8'h77, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h0,4'h0,8'h00)));
    tbl.push_back(v(0, 1,W,3,8'h77, 0,R,0,8'h00, 0, e(1,0,1,0,0,4'h3,4'h0,8'h77)));
    tbl.push_back(v(0, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h3,4'h0,8'h77)));
    tbl.push_back(v(0, 1,I,6,8'h00, 1,I,8,8'h00, 1, e(0,1,0,1,0,4'h3,4'h8,8'h77)));
    tbl.push_back(v(0, 1,I,6,8'h00, 1,I,8,8'h00, 1, e(0,0,0,0,0,4'h3,4'h8,8'h77)));
    tbl.push_back(v(0, 1,I,6,8'h00, 1,I,8,8'h00, 1, e(0,1,0,1,0,4'h3,4'h8,8'h77)));
    tbl.push_back(v(0, 1,I,6,8'h00, 1,I,8,8'h00, 1, e(0,0,0,0,0,4'h3,4'h8,8'h77)));
    tbl.push_back(v(0, 1,I,6,8'h00, 1,I,8,8'h00, 1, e(0,1,0,1,0,4'h3,4'h8,8'h77)));
    tbl.push_back(v(0, 1,I,6,8'h00, 1,I,8,8'h00, 0, e(1,0,0,1,0,4'h3,4'h6,8'h77)));
    tbl.push_back(v(0, 0,R,0,8'h00, 0,R,0,8'h00, 0, e(0,0,0,0,0,4'h3,4'h6,8'h77)));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; lock1 = tbl[i].lk;
      req0 = tbl[i].r0; op0 = tbl[i].op0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; op1 = tbl[i].op1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      tick();
      got = {ack0, ack1, rf_write_en, rf_inc, rf_dec, rf_in_select, rf_outb_select, rf_in};
      check($sformatf("vec%0d", i), 32'(got), 32'(tbl[i].exp));
    end
    req0 = 0; req1 = 0; lock1 = 0; rst = 0;

    // Pair increment carries from low into high register.
    do_op(1, W, 4'd4, 8'hFF);
    do_op(1, W, 4'd5, 8'h00);
    do_op(1, I, 4'd4, 8'h00);
    do_op(1, R, 4'd4, 8'h00);
    tick();
    check("rdata1_inc_carry", 32'(rdata1), 32'h0100);

    // Pair at address 15 wraps to register 0.
    do_op(0, W, 4'd15, 8'hFF);
    do_op(0, W, 4'd0, 8'h00);
    do_op(0, D, 4'd15, 8'h00);
    do_op(0, R, 4'd15, 8'h00);
    tick();
    check("rdata0_dec_wrap", 32'(rdata0), 32'h00FE);

    do_op(0, W, 4'd15, 8'hFF);
    do_op(0, W, 4'd0, 8'h00);
    do_op(0, I, 4'd15, 8'h00);
    do_op(0, R, 4'd15, 8'h00);
    tick();
    check("rdata0_inc_wrap", 32'(rdata0), 32'h0100);
    check("rdata1_held", 32'(rdata1), 32'h0100);

    // Reset in the sampling cycle of a pending read clears everything.
    rst = 1'b1; req0 = 1'b1; op0 = R; addr0 = 4'd15;
    tick();
    check("rst_no_issue", 32'({ack0, ack1, rf_write_en, rf_inc, rf_dec}), 32'd0);
    check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    rst = 1'b0; req0 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
